// File: rtl/riscv_pkg.sv
// Shared encodings for the factorial demo core.
// Opcodes, function fields, GPIO offsets and ALU ops.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] GPIO_OUT_OFS = 32'h0;
  localparam logic [31:0] GPIO_IN_OFS  = 32'h4;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_MUL,
    ALU_PASS
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_LOAD,
    WB_PC4
  } wb_sel_e;

endpackage

// File: rtl/rv_regfile.sv
// 32-entry register file, two async reads, one write.
// x0 reads zero; all entries clear on reset.
module rv_regfile #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [4:0]   ra1_i,
  input  logic [4:0]   ra2_i,
  output logic [W-1:0] rd1_o,
  output logic [W-1:0] rd2_o,
  input  logic         we_i,
  input  logic [4:0]   wa_i,
  input  logic [W-1:0] wd_i
);

  logic [W-1:0] regs_q [32];

  assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

  // Register write; x0 never takes a value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

endmodule

// File: rtl/riscv_factorial.sv
// Single-cycle RV32 subset running a fixed n! program.
// Reads n from GPIO IN, writes low byte of n! to GPIO OUT.
module riscv_factorial #(
  parameter logic [31:0] GPIO_BASE = 32'h0000_0100,
  parameter int          XLEN      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gpio_port_in,
  output logic [7:0] gpio_port_out
);
  import riscv_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d, pc4;
  logic [7:0]      gpio_q, gpio_d;
  logic [31:0]     insn;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val, op_b, alu_res;
  logic [XLEN-1:0] ld_data, wb_data;

  logic is_addi, is_add, is_sub, is_mul;
  logic is_lui, is_lw, is_sw, is_br, is_jal;
  logic rf_we, st_en, br_en, jal_en, take;
  alu_op_e alu_op;
  wb_sel_e wb_sel;

  // Program ROM; anything outside the program is a NOP
  always_comb begin
    insn = NOP_INSN;
    if (pc_q[XLEN-1:8] == '0) begin
      unique case (pc_q[7:2])
        6'h00:   insn = 32'h1000_0513;
        6'h01:   insn = 32'h0045_2583;
        6'h02:   insn = 32'h0010_0613;
        6'h03:   insn = 32'h0010_0693;
        6'h04:   insn = 32'h00B6_D863;
        6'h05:   insn = 32'h02B6_0633;
        6'h06:   insn = 32'hFFF5_8593;
        6'h07:   insn = 32'hFF5F_F06F;
        6'h08:   insn = 32'h00C5_2023;
        6'h09:   insn = 32'hFE1F_F06F;
        default: insn = NOP_INSN;
      endcase
    end
  end

  assign opc = insn[6:0];
  assign rd  = insn[11:7];
  assign f3  = insn[14:12];
  assign rs1 = insn[19:15];
  assign rs2 = insn[24:20];
  assign f7  = insn[31:25];

  assign imm_i = {{(XLEN-12){insn[31]}}, insn[31:20]};
  assign imm_s = {{(XLEN-12){insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b = {{(XLEN-13){insn[31]}}, insn[31], insn[7],
                  insn[30:25], insn[11:8], 1'b0};
  assign imm_u = {insn[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){insn[31]}}, insn[31], insn[19:12],
                  insn[20], insn[30:21], 1'b0};

  assign is_addi = (opc == OPC_OP_IMM) && (f3 == F3_ADD);
  assign is_add  = (opc == OPC_OP) && (f3 == F3_ADD) && (f7 == F7_BASE);
  assign is_sub  = (opc == OPC_OP) && (f3 == F3_ADD) && (f7 == F7_SUB);
  assign is_mul  = (opc == OPC_OP) && (f3 == F3_ADD) && (f7 == F7_MULDIV);
  assign is_lui  = (opc == OPC_LUI);
  assign is_lw   = (opc == OPC_LOAD) && (f3 == F3_LW);
  assign is_sw   = (opc == OPC_STORE) && (f3 == F3_SW);
  assign is_br   = (opc == OPC_BRANCH) &&
                   ((f3 == F3_BEQ) || (f3 == F3_BNE) ||
                    (f3 == F3_BLT) || (f3 == F3_BGE));
  assign is_jal  = (opc == OPC_JAL);

  rv_regfile #(.W(XLEN)) u_rf (
    .clk_i  (clk),
    .rst_ni (rst),
    .ra1_i  (rs1),
    .ra2_i  (rs2),
    .rd1_o  (rs1_val),
    .rd2_o  (rs2_val),
    .we_i   (rf_we),
    .wa_i   (rd),
    .wd_i   (wb_data)
  );

  // Decode into datapath controls; unknown encodings fall to NOP
  always_comb begin
    alu_op = ALU_ADD;
    op_b   = imm_i;
    rf_we  = 1'b0;
    wb_sel = WB_ALU;
    st_en  = 1'b0;
    br_en  = 1'b0;
    jal_en = 1'b0;
    unique case (1'b1)
      is_addi: rf_we = 1'b1;
      is_add: begin
        rf_we = 1'b1;
        op_b  = rs2_val;
      end
      is_sub: begin
        rf_we  = 1'b1;
        op_b   = rs2_val;
        alu_op = ALU_SUB;
      end
      is_mul: begin
        rf_we  = 1'b1;
        op_b   = rs2_val;
        alu_op = ALU_MUL;
      end
      is_lui: begin
        rf_we  = 1'b1;
        op_b   = imm_u;
        alu_op = ALU_PASS;
      end
      is_lw: begin
        rf_we  = 1'b1;
        wb_sel = WB_LOAD;
      end
      is_sw: begin
        st_en = 1'b1;
        op_b  = imm_s;
      end
      is_br: br_en = 1'b1;
      is_jal: begin
        jal_en = 1'b1;
        rf_we  = 1'b1;
        wb_sel = WB_PC4;
      end
      default: ;
    endcase
  end

  // ALU; loads and stores reuse the adder for the address
  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      ALU_ADD:  alu_res = rs1_val + op_b;
      ALU_SUB:  alu_res = rs1_val - op_b;
      ALU_MUL:  alu_res = rs1_val * op_b;
      ALU_PASS: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  assign ld_data = (alu_res == GPIO_BASE + GPIO_IN_OFS) ?
                   {{(XLEN-8){1'b0}}, gpio_port_in} : '0;

  // Write-back source select
  always_comb begin
    wb_data = alu_res;
    unique case (wb_sel)
      WB_LOAD: wb_data = ld_data;
      WB_PC4:  wb_data = pc4;
      default: wb_data = alu_res;
    endcase
  end

  // Signed/equality branch compare
  always_comb begin
    take = 1'b0;
    unique case (f3)
      F3_BEQ:  take = (rs1_val == rs2_val);
      F3_BNE:  take = (rs1_val != rs2_val);
      F3_BLT:  take = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  take = ($signed(rs1_val) >= $signed(rs2_val));
      default: take = 1'b0;
    endcase
  end

  assign pc4 = pc_q + XLEN'(4);

  // Next PC and GPIO output register value
  always_comb begin
    pc_d   = pc4;
    gpio_d = gpio_q;
    if (br_en && take) pc_d = pc_q + imm_b;
    else if (jal_en)   pc_d = pc_q + imm_j;
    if (st_en && (alu_res == GPIO_BASE + GPIO_OUT_OFS))
      gpio_d = rs2_val[7:0];
  end

  // Architectural state outside the register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= '0;
      gpio_q <= 8'h00;
    end else begin
      pc_q   <= pc_d;
      gpio_q <= gpio_d;
    end
  end

  assign gpio_port_out = gpio_q;

endmodule

// File: tb/tb_riscv_factorial.sv
// Directed bench for the factorial core.
// Table of n / n! low byte / store latency plus corner sequences.
module tb_riscv_factorial;

  logic       clk;
  logic       rst;
  logic [7:0] gpio_port_in;
  logic [7:0] gpio_port_out;

  int n_chk;
  int n_pass;

  typedef struct {
    logic [7:0] n;
    logic [7:0] exp;
    int         edges;
  } vec_t;

  vec_t tbl [12];

  riscv_factorial dut (
    .clk           (clk),
    .rst           (rst),
    .gpio_port_in  (gpio_port_in),
    .gpio_port_out (gpio_port_out)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reset at a falling edge, release at the next falling edge
  task automatic do_reset(input logic [7:0] n);
    @(negedge clk);
    rst = 1'b0;
    gpio_port_in = n;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // From release: output is 0 before edge 'edges', exp right after
  task automatic run_pass(input string name, input logic [7:0] exp,
                          input int edges);
    repeat (edges - 1) @(posedge clk);
    #1 check({name, "_pre"}, {24'b0, gpio_port_out}, 32'h0);
    @(posedge clk);
    #1 check(name, {24'b0, gpio_port_out}, {24'b0, exp});
  endtask

  initial begin
    logic [31:0] pc_a;
    bit seen;
    n_chk  = 0;
    n_pass = 0;

    tbl[0]  = '{8'd0,   8'h01, 6};
    tbl[1]  = '{8'd1,   8'h01, 6};
    tbl[2]  = '{8'd2,   8'h02, 10};
    tbl[3]  = '{8'd4,   8'h18, 18};
    tbl[4]  = '{8'd5,   8'h78, 22};
    tbl[5]  = '{8'd6,   8'hD0, 26};
    tbl[6]  = '{8'd7,   8'hB0, 30};
    tbl[7]  = '{8'd8,   8'h80, 34};
    tbl[8]  = '{8'd9,   8'h80, 38};
    tbl[9]  = '{8'd10,  8'h00, 42};
    tbl[10] = '{8'd11,  8'h00, 46};
    tbl[11] = '{8'd255, 8'h00, 1022};

    // Reset held across several edges
    rst = 1'b0;
    gpio_port_in = 8'd3;
    #1 check("rst_out", {24'b0, gpio_port_out}, 32'h0);
    check("rst_pc", dut.pc_q, 32'h0);
    repeat (4) @(posedge clk);
    #1 check("rst_hold_out", {24'b0, gpio_port_out}, 32'h0);
    check("rst_hold_pc", dut.pc_q, 32'h0);

    // n=3: silent through edge 13, 0x06 on edge 14, then steady
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk);
      #1 if (gpio_port_out != 8'h00) seen = 1'b1;
    end
    check("n3_quiet", {31'b0, seen}, 32'h0);
    @(posedge clk);
    #1 check("n3_edge14", {24'b0, gpio_port_out}, 32'h06);
    seen = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1 if (gpio_port_out != 8'h06) seen = 1'b1;
    end
    check("n3_steady", {31'b0, seen}, 32'h0);

    // Input change 3->4 mid-run: 0x06 persists, later 0x18
    gpio_port_in = 8'd4;
    @(posedge clk);
    #1 check("n4_hold", {24'b0, gpio_port_out}, 32'h06);
    seen = 1'b0;
    for (int e = 0; e < 100 && !seen; e++) begin
      @(posedge clk);
      #1 if (gpio_port_out == 8'h18) seen = 1'b1;
    end
    check("n4_update", {31'b0, seen}, 32'h1);
    check("n4_value", {24'b0, gpio_port_out}, 32'h18);

    // Async reset mid-loop, no clock edge before the check
    repeat (7) @(posedge clk);
    #5 rst = 1'b0;
    #1 check("async_out", {24'b0, gpio_port_out}, 32'h0);
    check("async_pc", dut.pc_q, 32'h0);
    gpio_port_in = 8'd5;
    @(negedge clk);
    rst = 1'b1;
    run_pass("restart_n5", 8'h78, 22);

    // Table of operands
    for (int i = 0; i < 12; i++) begin
      do_reset(tbl[i].n);
      run_pass($sformatf("vec_n%0d", tbl[i].n), tbl[i].exp, tbl[i].edges);
    end

    // n=255 keeps looping with output 0 and PC inside the program
    repeat (37) @(posedge clk);
    #1 pc_a = dut.pc_q;
    @(posedge clk);
    #1 check("n255_pc_moves", {31'b0, dut.pc_q != pc_a}, 32'h1);
    check("n255_pc_range", {31'b0, dut.pc_q <= 32'h24}, 32'h1);
    check("n255_out", {24'b0, gpio_port_out}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
